// File: rtl/sad_search_ctrl_pkg.sv
// sad_search_ctrl_pkg: shared types and constants for the SAD search sequencer
package sad_search_ctrl_pkg;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
    localparam int DIM_W_DEF = 8;
    localparam int SAD_W = 32;
    localparam logic [SAD_W-1:0] SAD_INIT = 32'hFFFFFFFF;
endpackage

// File: rtl/sad_pos_counter.sv
// sad_pos_counter: row-major 2-D position counter, X fastest, wraps to (0,0) after the last position
module sad_pos_counter
    import sad_search_ctrl_pkg::*;
#(
    parameter int DIM_W = DIM_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_clear,
    input  logic             i_advance,
    input  logic [DIM_W-1:0] i_x_lim,
    input  logic [DIM_W-1:0] i_y_lim,
    output logic [DIM_W-1:0] o_x,
    output logic [DIM_W-1:0] o_y,
    output logic             o_last
);
    logic [DIM_W-1:0] r_x, r_y;
    logic w_x_end;
    assign w_x_end = r_x == i_x_lim;
    assign o_last  = w_x_end && r_y == i_y_lim;
    assign o_x     = r_x;
    assign o_y     = r_y;
    // step through positions; the limits are inclusive
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_advance) begin
            r_x <= w_x_end ? '0 : r_x + 1'b1;
            r_y <= o_last ? '0 : (w_x_end ? r_y + 1'b1 : r_y);
        end
    end
endmodule

// File: rtl/sad_search_ctrl.sv
// sad_search_ctrl: issues every window position to the SAD datapath and tracks the minimum result
module sad_search_ctrl
    import sad_search_ctrl_pkg::*;
#(
    parameter int MAX_INFLIGHT = 8,
    parameter int DIM_W        = DIM_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [DIM_W-1:0] i_frame_rows,
    input  logic [DIM_W-1:0] i_frame_cols,
    input  logic [DIM_W-1:0] i_win_rows,
    input  logic [DIM_W-1:0] i_win_cols,
    output logic             o_issue_valid,
    input  logic             i_issue_ready,
    output logic [DIM_W-1:0] o_issue_x,
    output logic [DIM_W-1:0] o_issue_y,
    input  logic             i_result_valid,
    input  logic [SAD_W-1:0] i_result_sad,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_cfg_err,
    output logic [DIM_W-1:0] o_best_x,
    output logic [DIM_W-1:0] o_best_y,
    output logic [SAD_W-1:0] o_best_sad
);
    localparam int IW = $clog2(MAX_INFLIGHT + 1);

    state_t           r_state, w_next;
    logic [IW-1:0]    r_inflight;
    logic [DIM_W-1:0] r_x_lim, r_y_lim, w_ret_x, w_ret_y;
    logic [DIM_W-1:0] r_best_x, r_best_y;
    logic [SAD_W-1:0] r_best_sad;
    logic             r_cfg_err;
    logic             w_legal, w_accept, w_xfer, w_retire, w_iss_last, w_ret_last;

    assign w_legal  = |i_frame_rows && |i_frame_cols && |i_win_rows && |i_win_cols &&
                      i_win_rows <= i_frame_rows && i_win_cols <= i_frame_cols;
    assign w_accept = i_start && r_state == S_IDLE;
    assign w_xfer   = o_issue_valid && i_issue_ready;
    // results only count while a search is active and something is outstanding
    assign w_retire = i_result_valid && |r_inflight && (r_state == S_RUN || r_state == S_DRAIN);

    assign o_cfg_err  = r_cfg_err;
    assign o_best_x   = r_best_x;
    assign o_best_y   = r_best_y;
    assign o_best_sad = r_best_sad;

    sad_pos_counter #(.DIM_W(DIM_W)) u_issue_pos (
        .i_clk(i_clk), .i_reset(i_reset), .i_clear(w_accept), .i_advance(w_xfer),
        .i_x_lim(r_x_lim), .i_y_lim(r_y_lim),
        .o_x(o_issue_x), .o_y(o_issue_y), .o_last(w_iss_last)
    );

    // results return in issue order, so a second counter reproduces their coordinates
    sad_pos_counter #(.DIM_W(DIM_W)) u_retire_pos (
        .i_clk(i_clk), .i_reset(i_reset), .i_clear(w_accept), .i_advance(w_retire),
        .i_x_lim(r_x_lim), .i_y_lim(r_y_lim),
        .o_x(w_ret_x), .o_y(w_ret_y), .o_last(w_ret_last)
    );

    // state register
    always_ff @(posedge i_clk) begin
        r_state <= i_reset ? S_IDLE : w_next;
    end

    // next state; DRAIN finishes on the edge that retires the final position
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = w_accept ? (w_legal ? S_RUN : S_DONE) : S_IDLE;
            S_RUN:   w_next = (w_xfer && w_iss_last) ? S_DRAIN : S_RUN;
            S_DRAIN: w_next = (r_inflight == '0 || (w_retire && w_ret_last)) ? S_DONE : S_DRAIN;
            default: w_next = S_IDLE;
        endcase
    end

    // state-decoded outputs
    always_comb begin
        o_issue_valid = r_state == S_RUN && r_inflight < IW'(MAX_INFLIGHT);
        o_busy        = r_state == S_RUN || r_state == S_DRAIN;
        o_done        = r_state == S_DONE;
    end

    // position limits captured with the configuration
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_x_lim <= '0;
            r_y_lim <= '0;
        end else if (w_accept) begin
            r_x_lim <= i_frame_cols - i_win_cols;
            r_y_lim <= i_frame_rows - i_win_rows;
        end
    end

    // issued-but-unretired request count
    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_inflight <= '0;
        else
            r_inflight <= r_inflight + IW'(w_xfer) - IW'(w_retire);
    end

    // running minimum; strict compare keeps the earliest position on ties
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_best_x   <= '0;
            r_best_y   <= '0;
            r_best_sad <= '0;
            r_cfg_err  <= 1'b0;
        end else if (w_accept) begin
            r_best_x   <= '0;
            r_best_y   <= '0;
            r_best_sad <= SAD_INIT;
            r_cfg_err  <= !w_legal;
        end else if (w_retire && i_result_sad < r_best_sad) begin
            r_best_x   <= w_ret_x;
            r_best_y   <= w_ret_y;
            r_best_sad <= i_result_sad;
        end
    end
endmodule

// File: tb/tb_sad_search_ctrl.sv
// tb_sad_search_ctrl: directed checks of the SAD search sequencer against a fixed-latency datapath model
module tb_sad_search_ctrl;
    localparam int MAXI = 8;

    typedef struct {
        int          due;
        logic [31:0] sad;
    } ent_t;

    logic        clk = 1'b0;
    logic        i_reset, i_start, i_issue_ready, i_result_valid;
    logic [7:0]  i_frame_rows, i_frame_cols, i_win_rows, i_win_cols;
    logic [31:0] i_result_sad;
    logic        o_issue_valid, o_busy, o_done, o_cfg_err;
    logic [7:0]  o_issue_x, o_issue_y, o_best_x, o_best_y;
    logic [31:0] o_best_sad;

    int   n_chk = 0, n_fail = 0;
    int   cyc = 0, lat = 7, mode = 0, xl = 0;
    int   ex = 0, ey = 0, n_iss = 0, n_ret = 0;
    int   done_cnt = 0, done_cyc = -1, start_cyc = 0;
    int   px = 0, py = 0;
    bit   rnd_rdy = 0, prev_stall = 0;
    ent_t q[$];

    always #5 clk = ~clk;

    sad_search_ctrl #(.MAX_INFLIGHT(MAXI), .DIM_W(8)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_start(i_start),
        .i_frame_rows(i_frame_rows), .i_frame_cols(i_frame_cols),
        .i_win_rows(i_win_rows), .i_win_cols(i_win_cols),
        .o_issue_valid(o_issue_valid), .i_issue_ready(i_issue_ready),
        .o_issue_x(o_issue_x), .o_issue_y(o_issue_y),
        .i_result_valid(i_result_valid), .i_result_sad(i_result_sad),
        .o_busy(o_busy), .o_done(o_done), .o_cfg_err(o_cfg_err),
        .o_best_x(o_best_x), .o_best_y(o_best_y), .o_best_sad(o_best_sad)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] get_sad(input int x, input int y);
        if (mode == 0) return (x == 2 && y == 1) ? 32'd5 : 32'(40 - x - 4 * y);
        if (mode == 1) return 32'd10;
        return ((x == 3 && y == 2) || (x == 1 && y == 3)) ? 32'd7 : 32'd50;
    endfunction

    // one cycle of the datapath model, driven and observed at the falling edge
    task automatic step(input logic s);
        int inf;
        @(negedge clk);
        cyc++;
        inf = n_iss - n_ret;
        if (inf >= MAXI) check("inflight_cap", 32'(o_issue_valid), 32'd0);
        if (prev_stall) begin
            check("stall_valid", 32'(o_issue_valid), 32'd1);
            check("stall_x", 32'(o_issue_x), 32'(px));
            check("stall_y", 32'(o_issue_y), 32'(py));
        end
        if (o_done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
        end
        i_start = s;
        i_issue_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        if (q.size() > 0 && q[0].due == cyc) begin
            i_result_valid = 1'b1;
            i_result_sad   = q[0].sad;
            void'(q.pop_front());
            n_ret++;
        end else begin
            i_result_valid = 1'b0;
            i_result_sad   = '0;
        end
        if (o_issue_valid && i_issue_ready) begin
            check("issue_x", 32'(o_issue_x), 32'(ex));
            check("issue_y", 32'(o_issue_y), 32'(ey));
            q.push_back('{cyc + lat, get_sad(ex, ey)});
            n_iss++;
            if (ex == xl) begin
                ex = 0;
                ey++;
            end else ex++;
        end
        prev_stall = o_issue_valid && !i_issue_ready;
        px = int'(o_issue_x);
        py = int'(o_issue_y);
    endtask

    task automatic setup(input logic [7:0] fr, fc, wr, wc, input int l, input bit rnd, input int m);
        i_frame_rows = fr; i_frame_cols = fc; i_win_rows = wr; i_win_cols = wc;
        lat = l; rnd_rdy = rnd; mode = m; xl = int'(fc) - int'(wc);
        ex = 0; ey = 0; n_iss = 0; n_ret = 0; done_cnt = 0; done_cyc = -1;
        prev_stall = 0; q.delete();
    endtask

    task automatic run_search(input logic [7:0] fr, fc, wr, wc, input int l, input bit rnd,
                              input int m, input int restart);
        setup(fr, fc, wr, wc, l, rnd, m);
        step(1'b1);
        start_cyc = cyc;
        for (int i = 1; i < 3000; i++) begin
            if (done_cnt > 0 && cyc >= done_cyc + 2) break;
            step(restart == i);
        end
        check("done_seen", 32'(done_cnt > 0), 32'd1);
        check("done_pulses", 32'(done_cnt), 32'd1);
    endtask

    task automatic expect_best(input string tag, input int n, input int bx, input int by,
                               input logic [31:0] bs, input logic err);
        check({tag, "_issues"}, 32'(n_iss), 32'(n));
        check({tag, "_best_x"}, 32'(o_best_x), 32'(bx));
        check({tag, "_best_y"}, 32'(o_best_y), 32'(by));
        check({tag, "_best_sad"}, o_best_sad, bs);
        check({tag, "_cfg_err"}, 32'(o_cfg_err), 32'(err));
        check({tag, "_busy"}, 32'(o_busy), 32'd0);
    endtask

    task automatic expect_zero(input string tag);
        check({tag, "_valid"}, 32'(o_issue_valid), 32'd0);
        check({tag, "_x"}, 32'(o_issue_x), 32'd0);
        check({tag, "_y"}, 32'(o_issue_y), 32'd0);
        check({tag, "_busy"}, 32'(o_busy), 32'd0);
        check({tag, "_done"}, 32'(o_done), 32'd0);
        check({tag, "_cfg_err"}, 32'(o_cfg_err), 32'd0);
        check({tag, "_best_x"}, 32'(o_best_x), 32'd0);
        check({tag, "_best_y"}, 32'(o_best_y), 32'd0);
        check({tag, "_best_sad"}, o_best_sad, 32'd0);
    endtask

    initial begin
        i_reset = 1'b1; i_start = 1'b0; i_issue_ready = 1'b0;
        i_result_valid = 1'b0; i_result_sad = '0;
        i_frame_rows = '0; i_frame_cols = '0; i_win_rows = '0; i_win_cols = '0;
        repeat (2) @(negedge clk);
        expect_zero("rst");
        i_reset = 1'b0;

        run_search(8'd4, 8'd4, 8'd2, 8'd2, 7, 1'b0, 0, 0);
        expect_best("uniq", 9, 2, 1, 32'd5, 1'b0);
        check("uniq_done_cyc", 32'(done_cyc), 32'(start_cyc + 17));

        run_search(8'd4, 8'd4, 8'd2, 8'd2, 7, 1'b0, 1, 0);
        expect_best("ties", 9, 0, 0, 32'd10, 1'b0);

        run_search(8'd2, 8'd2, 8'd2, 8'd2, 7, 1'b0, 0, 0);
        expect_best("one", 1, 0, 0, 32'd40, 1'b0);
        check("one_done_cyc", 32'(done_cyc), 32'(start_cyc + 9));

        run_search(8'd5, 8'd6, 8'd2, 8'd2, 20, 1'b1, 2, 0);
        expect_best("stall", 20, 3, 2, 32'd7, 1'b0);

        run_search(8'd4, 8'd4, 8'd2, 8'd5, 7, 1'b0, 0, 0);
        expect_best("illegal", 0, 0, 0, 32'hFFFFFFFF, 1'b1);
        check("illegal_done_cyc", 32'(done_cyc), 32'(start_cyc + 1));

        setup(8'd4, 8'd4, 8'd2, 8'd2, 7, 1'b0, 0);
        step(1'b1);
        for (int i = 0; i < 50 && n_iss < 3; i++) step(1'b0);
        check("pre_rst_issues", 32'(n_iss), 32'd3);
        @(negedge clk);
        i_reset = 1'b1; i_start = 1'b0; i_issue_ready = 1'b0; i_result_valid = 1'b0;
        @(negedge clk);
        i_reset = 1'b0;
        expect_zero("midrst");
        for (int i = 0; i < 3; i++) begin
            i_result_valid = 1'b1;
            i_result_sad   = 32'd1;
            @(negedge clk);
        end
        i_result_valid = 1'b0;
        i_result_sad   = '0;
        @(negedge clk);
        expect_zero("stale");
        q.delete();

        run_search(8'd4, 8'd4, 8'd2, 8'd2, 7, 1'b0, 0, 0);
        expect_best("after_rst", 9, 2, 1, 32'd5, 1'b0);

        run_search(8'd4, 8'd4, 8'd2, 8'd2, 7, 1'b0, 0, 3);
        expect_best("restart", 9, 2, 1, 32'd5, 1'b0);
        check("restart_done_cyc", 32'(done_cyc), 32'(start_cyc + 17));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sad_search_ctrl.md
# sad_search_ctrl

Sequencer for the SAD (sum of absolute differences) custom-instruction datapath in the deep EX1–EX7 pipeline. It scans every window position of a frame in row-major order and issues one position request per accepted handshake to the SAD datapath. It retires the in-order SAD results and tracks the minimum SAD and its coordinates, which feed the outx/outy/sad values written back at the end of the pipeline.

## Interface
Parameters:
- MAX_INFLIGHT, 8, maximum issued-but-unretired requests (1..15)
- DIM_W, 8, width of frame, window and coordinate fields

Ports:
- Clk  in  1  clock; single clock domain
- Reset  in  1  synchronous, active-high
- Start  in  1  one-cycle pulse; begins a search; ignored unless IDLE
- Frame_Rows, Frame_Cols  in  DIM_W  frame dimensions, sampled on accepted Start
- Win_Rows, Win_Cols  in  DIM_W  window dimensions, sampled on accepted Start
- Issue_Valid  out  1  position request valid
- Issue_Ready  in  1  datapath accepts request
- Issue_X, Issue_Y  out  DIM_W  column / row of requested position
- Result_Valid  in  1  one SAD result returned; results arrive in issue order
- Result_Sad  in  32  unsigned SAD of oldest in-flight request
- Busy  out  1  high in RUN and DRAIN
- Done  out  1  one-cycle pulse at end of search
- Cfg_Err  out  1  last search had an illegal configuration
- Best_X, Best_Y  out  DIM_W  coordinates of the minimum SAD
- Best_Sad  out  32  minimum SAD

## Operation
- States:
  - IDLE -> RUN on Start with a legal configuration.
  - IDLE -> DONE on Start with an illegal configuration.
  - RUN -> DRAIN when the last position is transferred.
  - DRAIN -> DONE when the in-flight count reaches 0 and no result is pending.
  - DONE -> IDLE unconditionally.
- Illegal configuration: any dimension = 0, Win_Rows > Frame_Rows, or Win_Cols > Frame_Cols.
  - Cfg_Err is set; no request is issued.
  - Best_Sad = 0xFFFFFFFF; Best_X = Best_Y = 0.
- On accepted Start:
  - Best_Sad <= 0xFFFFFFFF; Best_X, Best_Y <= 0; Cfg_Err <= legality result.
  - Issue and retire position counters <= (0,0).
- Position range: X = 0..Frame_Cols-Win_Cols, Y = 0..Frame_Rows-Win_Rows. X increments fastest; X wraps to 0 while Y increments.
- Issue_Valid = (state == RUN) && (inflight < MAX_INFLIGHT).
  - A transfer occurs when Issue_Valid && Issue_Ready.
  - Each transfer advances the issue counter and increments inflight.
- Retire: Result_Valid with inflight > 0 decrements inflight and advances the retire counter.
  - If Result_Sad < Best_Sad (strictly less), Best_* <= (retire X, retire Y, Result_Sad).
  - Ties keep the earliest position in row-major order.
- A transfer and a retire in the same cycle leave inflight unchanged.
- Result_Valid with inflight == 0, or in IDLE/DONE, is ignored.
- Start while Busy or in DONE is ignored.
- Best_*, Cfg_Err hold after DONE until the next accepted Start.
- Reset in any state: state -> IDLE, inflight -> 0, all outputs -> 0.
  - Results arriving after reset are ignored.

## Timing
- Reset values: Issue_Valid, Issue_X, Issue_Y, Busy, Done, Cfg_Err, Best_X, Best_Y, Best_Sad all 0.
- Start sampled at edge t: state = RUN and Issue_Valid can be high in cycle t+1.
- Issue_X/Issue_Y are stable while Issue_Valid is high and not accepted.
  - Issue_Valid drops only on a transfer that fills MAX_INFLIGHT or transfers the last position.
- Best_* update on the clock edge that retires the result.
- Done is high the cycle after the last retire. Best_* are final while Done is high.
- Example, 1 position, always-ready datapath of latency L, Start at t:
  - Issue transfer in cycle t+1.
  - Result_Valid at t+1+L.
  - Done at t+2+L.
- Illegal configuration: Done one cycle after Start, with Cfg_Err = 1.
- Throughput: one issue per cycle when Issue_Ready = 1 and inflight < MAX_INFLIGHT.

## Structure
- Shared package:
  - state enum (IDLE, RUN, DRAIN, DONE)
  - SAD_INIT = 32'hFFFFFFFF
  - DIM_W default
  - SAD result width (32)
- Sub-module sad_pos_counter: row-major 2-D counter.
  - Inputs: clear, advance, X limit, Y limit.
  - Outputs: X, Y, last flag.
  - Instantiated twice: issue side and retire side. Retire coordinates therefore need no position FIFO.
- Inflight counter width: $clog2(MAX_INFLIGHT+1).

## Test plan
- 4x4 frame, 2x2 window, latency-7 always-ready model, unique minimum 5 at (2,1) -> exactly 9 issues in row-major order, Best_X=2, Best_Y=1, Best_Sad=5, single Done pulse.
- All nine SADs = 10 -> Best_X=0, Best_Y=0, Best_Sad=10.
- MAX_INFLIGHT=8, latency 20, random Issue_Ready -> inflight never exceeds 8; X/Y held while stalled; no position lost or duplicated; correct minimum.
- Win_Cols=5, Frame_Cols=4 -> zero issues; Done one cycle after Start; Cfg_Err=1; Best_Sad=0xFFFFFFFF.
- Reset after 3 issues, then stale Result_Valid pulses -> all outputs 0, IDLE, pulses ignored; a following Start completes normally.
- Second Start pulse during RUN -> ignored; issue sequence and result identical to the single-Start run.
